jtkicker_pcm_player: RTL and testbench

Plays raw 8-bit unsigned PCM samples stored in the PCM region of SDRAM. It sits between the sound CPU's PCM control latch and the PCM ROM slot of jtframe_rom, and it drives the pcm_addr/pcm_data/pcm_ok lines for that slot. It fetches one byte ahead, so the signed sample output updates exactly on each sample-rate clock enable. Playback ends on the 8'hFF terminator or on a CPU stop request.

---
 rtl/jtkicker_pcm_player.sv | 149 ++++++++++++++
 tb/tb_jtkicker_pcm_player.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtkicker_pcm_player.sv
// Streams 8-bit unsigned PCM bytes from the PCM ROM slot and outputs them as signed samples, one byte fetched ahead.
// Latency: start -> rom_cs 1 cycle; each sample lands on the cen after its byte is buffered.
// Backpressure: a slow rom_ok stalls the fetch; a cen with an empty buffer sets sticky underrun and holds snd.
module jtkicker_pcm_player #(
    parameter int          AW      = 16,
    parameter logic [7:0]  ENDMARK = 8'hFF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic          stop,
    output logic          busy,
    output logic          rom_cs,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok,
    output logic [7:0]    snd,
    output logic          sample,
    output logic          underrun
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WAIT  = 3'd2,
        FULL  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]    pcm_buf_q, pcm_buf_d;
    logic          buf_valid_q, buf_valid_d;
    logic          busy_q, busy_d;
    logic          rom_cs_q, rom_cs_d;
    logic [7:0]    snd_q, snd_d;
    logic          sample_q, sample_d;
    logic          underrun_q, underrun_d;

    // Next-state logic: start beats stop, stop beats the normal sequence.
    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        pcm_buf_d   = pcm_buf_q;
        buf_valid_d = buf_valid_q;
        busy_d      = busy_q;
        snd_d       = snd_q;
        sample_d    = 1'b0;
        underrun_d  = underrun_q;

        if (start) begin
            // Restart from any state; snd keeps its value until the next played byte.
            state_d     = ADDR;
            rom_addr_d  = start_addr;
            busy_d      = 1'b1;
            underrun_d  = 1'b0;
            buf_valid_d = 1'b0;
        end else if (stop && (state_q != IDLE)) begin
            // Abort: silence output, keep rom_addr where it was.
            state_d     = IDLE;
            busy_d      = 1'b0;
            snd_d       = 8'd0;
            buf_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    snd_d = 8'd0;
                end
                ADDR: begin
                    // rom_ok here still refers to the previous address, so it is ignored.
                    if (cen) underrun_d = 1'b1;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (cen) underrun_d = 1'b1;
                    if (rom_ok) begin
                        pcm_buf_d   = rom_data;
                        buf_valid_d = 1'b1;
                        if (rom_data == ENDMARK) begin
                            state_d = DRAIN;
                        end else begin
                            rom_addr_d = rom_addr_q + 1'b1;
                            state_d    = FULL;
                        end
                    end
                end
                FULL: begin
                    if (cen && buf_valid_q) begin
                        snd_d       = pcm_buf_q ^ 8'h80;
                        sample_d    = 1'b1;
                        buf_valid_d = 1'b0;
                        state_d     = ADDR;
                    end
                end
                DRAIN: begin
                    // Terminator is consumed by this cen but never played.
                    if (cen) begin
                        snd_d       = 8'd0;
                        sample_d    = 1'b1;
                        busy_d      = 1'b0;
                        buf_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Chip select is registered from the next state so it is high for all of ADDR and WAIT.
        rom_cs_d = (state_d == ADDR) || (state_d == WAIT);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rom_addr_q  <= '0;
            pcm_buf_q   <= 8'd0;
            buf_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rom_cs_q    <= 1'b0;
            snd_q       <= 8'd0;
            sample_q    <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            pcm_buf_q   <= pcm_buf_d;
            buf_valid_q <= buf_valid_d;
            busy_q      <= busy_d;
            rom_cs_q    <= rom_cs_d;
            snd_q       <= snd_d;
            sample_q    <= sample_d;
            underrun_q  <= underrun_d;
        end
    end

    assign busy     = busy_q;
    assign rom_cs   = rom_cs_q;
    assign rom_addr = rom_addr_q;
    assign snd      = snd_q;
    assign sample   = sample_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_jtkicker_pcm_player.sv
// Directed bench for jtkicker_pcm_player with a behavioural ROM slot and a free-running cen.
// Latency: ROM slot answers a programmable number of cycles after cs/address settle.
// Backpressure: ROM latency longer than the cen period provokes underrun.
module tb_jtkicker_pcm_player;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cen = 1'b0;
    logic        start = 1'b0;
    logic [15:0] start_addr = 16'd0;
    logic        stop = 1'b0;
    logic        busy;
    logic        rom_cs;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_ok;
    logic [7:0]  snd;
    logic        sample;
    logic        underrun;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  rom [0:65535];
    int          lat = 3;
    bit          stale = 1'b0;
    int          lat_cnt = 0;
    logic [15:0] prev_addr = 16'd0;
    logic [7:0]  data_lag = 8'd0;
    int          cen_per = 20;
    int          cen_cnt = 0;
    logic [7:0]  played [$];

    jtkicker_pcm_player #(.AW(16), .ENDMARK(8'hFF)) dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .start      (start),
        .start_addr (start_addr),
        .stop       (stop),
        .busy       (busy),
        .rom_cs     (rom_cs),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rom_ok     (rom_ok),
        .snd        (snd),
        .sample     (sample),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    // ROM slot model: ok after lat cycles of stable cs+address; in stale mode ok is stuck high
    // and data lags the address by one cycle.
    assign rom_ok   = stale ? 1'b1 : (rom_cs && (lat_cnt >= lat));
    assign rom_data = stale ? data_lag : (rom_ok ? rom[rom_addr] : 8'h5A);

    always @(posedge clk) begin
        if (!rom_cs || (rom_addr != prev_addr)) lat_cnt <= 0;
        else                                    lat_cnt <= lat_cnt + 1;
        prev_addr <= rom_addr;
        data_lag  <= rom[rom_addr];
    end

    // Free-running sample-rate enable, changed just after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (cen_cnt >= cen_per - 1) begin
                cen = 1'b1;
                cen_cnt = 0;
            end else begin
                cen = 1'b0;
                cen_cnt = cen_cnt + 1;
            end
        end
    end

    // Record every played sample value.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sample) played.push_back(snd);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue a start the cycle after a cen so the first fetch fits inside one cen period.
    task automatic do_start(input logic [15:0] a);
        int n;
        n = 0;
        @(negedge clk);
        while (!cen && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        @(negedge clk);
        start_addr = a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        while (busy && n < max) begin
            @(negedge clk);
            n = n + 1;
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic wait_played(input int cnt, input int max);
        int n;
        n = 0;
        while (played.size() < cnt && n < max) begin
            @(negedge clk);
            n = n + 1;
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
        rom[16'h1000] = 8'h80; rom[16'h1001] = 8'h00; rom[16'h1002] = 8'hFF;
        rom[16'h2000] = 8'h33; rom[16'h2001] = 8'hFF;
        rom[16'h3000] = 8'h7F; rom[16'h3001] = 8'h12; rom[16'h3002] = 8'hFF;
        rom[16'hFFFF] = 8'h10; rom[16'h0000] = 8'hFF;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_cs", rom_cs, 1'b0);
        check("rst_addr", rom_addr, 16'h0000);
        check("rst_snd", snd, 8'h00);
        check("rst_sample", sample, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Basic playback: 80,00,FF -> 00,80,then terminating 00
        played.delete();
        do_start(16'h1000);
        check("t1_cs_lat", rom_cs, 1'b1);
        check("t1_busy", busy, 1'b1);
        wait_idle("t1_end", 400);
        check("t1_count", played.size(), 3);
        if (played.size() == 3) begin
            check("t1_s0", played[0], 8'h00);
            check("t1_s1", played[1], 8'h80);
            check("t1_s2", played[2], 8'h00);
        end
        check("t1_addr", rom_addr, 16'h1002);
        check("t1_underrun", underrun, 1'b0);
        check("t1_cs_idle", rom_cs, 1'b0);

        // Stale rom_ok during address change (previous address holds FF)
        stale = 1'b1;
        played.delete();
        do_start(16'h2000);
        wait_idle("t2_end", 400);
        check("t2_count", played.size(), 2);
        if (played.size() >= 1) check("t2_s0", played[0], 8'hB3);
        check("t2_addr", rom_addr, 16'h2001);
        stale = 1'b0;

        // Underrun: slow ROM on the second byte
        lat = 3;
        played.delete();
        do_start(16'h3000);
        wait_played(1, 100);
        check("t3_s0", snd, 8'hFF);
        lat = 30;
        for (int n = 0; n < 60 && !underrun; n++) @(negedge clk);
        check("t3_underrun", underrun, 1'b1);
        check("t3_snd_held", snd, 8'hFF);
        check("t3_no_sample", played.size(), 1);
        wait_idle("t3_end", 400);
        check("t3_count", played.size(), 3);
        if (played.size() == 3) check("t3_s1", played[1], 8'h92);
        lat = 3;
        do_start(16'h1000);
        check("t3_clear", underrun, 1'b0);
        wait_idle("t3_end2", 400);

        // Stop in WAIT
        played.delete();
        do_start(16'h1000);
        wait_played(2, 100);
        check("t4_s1", snd, 8'h80);
        lat = 30;
        repeat (4) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("t4_busy", busy, 1'b0);
        check("t4_cs", rom_cs, 1'b0);
        check("t4_snd", snd, 8'h00);
        check("t4_addr", rom_addr, 16'h1002);
        repeat (60) @(negedge clk);
        check("t4_no_more", played.size(), 2);
        lat = 3;

        // Address wrap FFFF -> 0000
        played.delete();
        do_start(16'hFFFF);
        wait_idle("t5_end", 400);
        check("t5_count", played.size(), 2);
        if (played.size() >= 1) check("t5_s0", played[0], 8'h90);
        check("t5_addr", rom_addr, 16'h0000);

        // Asynchronous reset while in FULL
        played.delete();
        do_start(16'h3000);
        wait_played(1, 100);
        repeat (10) @(negedge clk);
        check("t6_busy_pre", busy, 1'b1);
        check("t6_snd_pre", snd, 8'hFF);
        #2;
        rst = 1'b0;
        #1;
        check("t6_busy", busy, 1'b0);
        check("t6_cs", rom_cs, 1'b0);
        check("t6_addr", rom_addr, 16'h0000);
        check("t6_snd", snd, 8'h00);
        check("t6_sample", sample, 1'b0);
        check("t6_underrun", underrun, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
